// File: rtl/tt_um_emern_scan_raster_pkg.sv
// Shared widths, setup timing and FSM encoding for the scanline rasterizer.
// The SPI frontend uses the same coordinate and colour widths.
package tt_um_emern_scan_raster_pkg;

  localparam int X_W          = 7;
  localparam int Y_W          = 6;
  localparam int COLOR_W      = 6;
  localparam int DEPTH_W      = 3;
  localparam int EW_DEF       = 16;
  localparam int XMAX_DEF     = 127;
  localparam int SETUP_CYCLES = 13;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACTIVE = 2'd2
  } state_t;

endpackage

// File: rtl/tt_um_emern_edge_setup.sv
// Serial edge-function setup: one shared signed multiplier walks 6 edges x 2 products,
// then a finalise step during which done is high and the top loads its accumulators.
module tt_um_emern_edge_setup
  import tt_um_emern_scan_raster_pkg::*;
#(
  parameter int EW = EW_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [13:0]     v0_x,
  input  logic [13:0]     v1_x,
  input  logic [13:0]     v2_x,
  input  logic [11:0]     v0_y,
  input  logic [11:0]     v1_y,
  input  logic [11:0]     v2_y,
  input  logic [5:0]      line_y,
  output logic [6*EW-1:0] init_flat,
  output logic [6*EW-1:0] dy_flat,
  output logic            done
);

  logic                 running;
  logic [3:0]           step;
  logic [2:0]           eidx;
  logic                 phase;
  logic                 p;
  logic [1:0]           k;
  logic [6:0]           x0, x1, x2, xa, xb;
  logic [5:0]           y0, y1, y2, ya, yb;
  logic signed [7:0]    dx, mul_a, mul_b;
  logic signed [6:0]    dy, ry;
  logic signed [EW-1:0] prod, acc_r;
  logic signed [EW-1:0] init_r [0:5];
  logic signed [EW-1:0] dy_r   [0:5];

  // Even steps form -xa*dy, odd steps subtract (y-ya)*dx; edges 0-2 are poly A, 3-5 poly B.
  assign eidx  = step[3:1];
  assign phase = step[0];
  assign done  = running && (step == 4'(SETUP_CYCLES - 1));

  always_comb begin
    p = (eidx >= 3'd3);
    k = p ? 2'(eidx - 3'd3) : eidx[1:0];
  end

  assign x0 = p ? v0_x[13:7] : v0_x[6:0];
  assign x1 = p ? v1_x[13:7] : v1_x[6:0];
  assign x2 = p ? v2_x[13:7] : v2_x[6:0];
  assign y0 = p ? v0_y[11:6] : v0_y[5:0];
  assign y1 = p ? v1_y[11:6] : v1_y[5:0];
  assign y2 = p ? v2_y[11:6] : v2_y[5:0];

  always_comb begin
    case (k)
      2'd0:    begin xa = x0; xb = x1; ya = y0; yb = y1; end
      2'd1:    begin xa = x1; xb = x2; ya = y1; yb = y2; end
      default: begin xa = x2; xb = x0; ya = y2; yb = y0; end
    endcase
  end

  assign dx    = $signed({1'b0, xb}) - $signed({1'b0, xa});
  assign dy    = $signed({1'b0, yb}) - $signed({1'b0, ya});
  assign ry    = $signed({1'b0, line_y}) - $signed({1'b0, ya});
  assign mul_a = phase ? dx : $signed({1'b0, xa});
  assign mul_b = phase ? $signed({ry[6], ry}) : $signed({dy[6], dy});
  assign prod  = mul_a * mul_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      running <= 1'b0;
      step    <= '0;
      acc_r   <= '0;
      for (int i = 0; i < 6; i++) begin
        init_r[i] <= '0;
        dy_r[i]   <= '0;
      end
    end else if (start) begin
      running <= 1'b1;
      step    <= '0;
    end else if (running) begin
      if (done) begin
        running <= 1'b0;
        step    <= '0;
      end else begin
        step <= step + 4'd1;
        if (!phase) begin
          acc_r      <= -prod;
          dy_r[eidx] <= EW'(dy);
        end else begin
          init_r[eidx] <= acc_r - prod;
        end
      end
    end
  end

  for (genvar i = 0; i < 6; i++) begin : g_flat
    assign init_flat[i*EW +: EW] = init_r[i];
    assign dy_flat[i*EW +: EW]   = dy_r[i];
  end

endmodule

// File: rtl/tt_um_emern_scan_raster.sv
// Per-scanline two-triangle rasterizer: snapshots polygon state at line start, runs the
// serial edge setup, then steps six edge accumulators one pixel per pix_step and resolves colour.
module tt_um_emern_scan_raster
  import tt_um_emern_scan_raster_pkg::*;
#(
  parameter int EW   = EW_DEF,
  parameter int XMAX = XMAX_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        line_start,
  input  logic [5:0]  line_y,
  input  logic        pix_step,
  input  logic [5:0]  bg_color_in,
  input  logic [11:0] poly_color_in,
  input  logic [13:0] v0_x_in,
  input  logic [13:0] v1_x_in,
  input  logic [13:0] v2_x_in,
  input  logic [11:0] v0_y_in,
  input  logic [11:0] v1_y_in,
  input  logic [11:0] v2_y_in,
  input  logic [5:0]  poly_depth_in,
  input  logic [1:0]  poly_enable_in,
  output logic [5:0]  color_out,
  output logic        color_valid,
  output logic        setup_busy,
  output logic        late_pulse
);

  state_t               state;
  logic [7:0]           x;
  logic [5:0]           y_s, bg_s, dep_s;
  logic [11:0]          col_s, v0y_s, v1y_s, v2y_s;
  logic [13:0]          v0x_s, v1x_s, v2x_s;
  logic [1:0]           en_s;
  logic signed [EW-1:0] acc    [0:5];
  logic signed [EW-1:0] init_v [0:5];
  logic signed [EW-1:0] dy_v   [0:5];
  logic [6*EW-1:0]      init_flat, dy_flat;
  logic                 setup_done;
  logic                 cov_a, cov_b;
  logic [5:0]           pix_color;

  tt_um_emern_edge_setup #(.EW(EW)) u_setup (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (line_start),
    .v0_x      (v0x_s),
    .v1_x      (v1x_s),
    .v2_x      (v2x_s),
    .v0_y      (v0y_s),
    .v1_y      (v1y_s),
    .v2_y      (v2y_s),
    .line_y    (y_s),
    .init_flat (init_flat),
    .dy_flat   (dy_flat),
    .done      (setup_done)
  );

  for (genvar i = 0; i < 6; i++) begin : g_unpack
    assign init_v[i] = init_flat[i*EW +: EW];
    assign dy_v[i]   = dy_flat[i*EW +: EW];
  end

  // Inclusive edges, either winding; an all-zero triangle has no area and never draws.
  function automatic logic poly_cov(input logic en, input logic signed [EW-1:0] e0,
                                    input logic signed [EW-1:0] e1, input logic signed [EW-1:0] e2);
    logic all_ge, all_le, all_zero;
    all_zero = (e0 == '0) && (e1 == '0) && (e2 == '0);
    all_ge   = !e0[EW-1] && !e1[EW-1] && !e2[EW-1];
    all_le   = (e0[EW-1] || e0 == '0) && (e1[EW-1] || e1 == '0) && (e2[EW-1] || e2 == '0);
    return en && (all_ge || all_le) && !all_zero;
  endfunction

  function automatic logic [5:0] resolve(input logic ca, input logic cb, input logic [11:0] col,
                                         input logic [5:0] dep, input logic [5:0] bg);
    if (ca && cb) return (dep[5:3] < dep[2:0]) ? col[11:6] : col[5:0];
    else if (ca)  return col[5:0];
    else if (cb)  return col[11:6];
    else          return bg;
  endfunction

  assign cov_a     = poly_cov(en_s[0], acc[0], acc[1], acc[2]);
  assign cov_b     = poly_cov(en_s[1], acc[3], acc[4], acc[5]);
  assign pix_color = resolve(cov_a, cov_b, col_s, dep_s, bg_s);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      x           <= '0;
      color_out   <= '0;
      color_valid <= 1'b0;
      setup_busy  <= 1'b0;
      late_pulse  <= 1'b0;
      y_s   <= '0; bg_s  <= '0; dep_s <= '0; col_s <= '0; en_s  <= '0;
      v0x_s <= '0; v1x_s <= '0; v2x_s <= '0;
      v0y_s <= '0; v1y_s <= '0; v2y_s <= '0;
      for (int i = 0; i < 6; i++) acc[i] <= '0;
    end else begin
      color_valid <= 1'b0;
      late_pulse  <= 1'b0;
      // A line start always wins: it drops any same-cycle pixel and restarts setup.
      if (line_start) begin
        state      <= ST_SETUP;
        setup_busy <= 1'b1;
        x          <= '0;
        y_s   <= line_y;       bg_s  <= bg_color_in;    dep_s <= poly_depth_in;
        col_s <= poly_color_in; en_s <= poly_enable_in;
        v0x_s <= v0_x_in; v1x_s <= v1_x_in; v2x_s <= v2_x_in;
        v0y_s <= v0_y_in; v1y_s <= v1_y_in; v2y_s <= v2_y_in;
        if (pix_step && state != ST_ACTIVE) late_pulse <= 1'b1;
      end else begin
        case (state)
          ST_IDLE: begin
            if (pix_step) late_pulse <= 1'b1;
          end
          ST_SETUP: begin
            if (pix_step) late_pulse <= 1'b1;
            if (setup_done) begin
              state      <= ST_ACTIVE;
              setup_busy <= 1'b0;
              for (int i = 0; i < 6; i++) acc[i] <= init_v[i];
            end
          end
          ST_ACTIVE: begin
            if (pix_step && x <= 8'(XMAX)) begin
              color_out   <= pix_color;
              color_valid <= 1'b1;
              x           <= x + 8'd1;
              for (int i = 0; i < 6; i++) acc[i] <= acc[i] + dy_v[i];
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tt_um_emern_scan_raster.sv
// Directed bench for the scanline rasterizer: reset, coverage, overlap, winding,
// late strobes, setup restart and snapshot behaviour.
module tb_tt_um_emern_scan_raster;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        line_start = 1'b0;
  logic [5:0]  line_y = '0;
  logic        pix_step = 1'b0;
  logic [5:0]  bg_color_in = '0;
  logic [11:0] poly_color_in = '0;
  logic [13:0] v0_x_in = '0, v1_x_in = '0, v2_x_in = '0;
  logic [11:0] v0_y_in = '0, v1_y_in = '0, v2_y_in = '0;
  logic [5:0]  poly_depth_in = '0;
  logic [1:0]  poly_enable_in = '0;
  logic [5:0]  color_out;
  logic        color_valid, setup_busy, late_pulse;

  int n_checks = 0;
  int n_fail   = 0;

  logic [5:0] pix_col  [0:127];
  logic       pix_vld  [0:127];
  logic       pix_hold [0:127];
  int         busy_cnt;

  tt_um_emern_scan_raster dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .line_start     (line_start),
    .line_y         (line_y),
    .pix_step       (pix_step),
    .bg_color_in    (bg_color_in),
    .poly_color_in  (poly_color_in),
    .v0_x_in        (v0_x_in),
    .v1_x_in        (v1_x_in),
    .v2_x_in        (v2_x_in),
    .v0_y_in        (v0_y_in),
    .v1_y_in        (v1_y_in),
    .v2_y_in        (v2_y_in),
    .poly_depth_in  (poly_depth_in),
    .poly_enable_in (poly_enable_in),
    .color_out      (color_out),
    .color_valid    (color_valid),
    .setup_busy     (setup_busy),
    .late_pulse     (late_pulse)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_tri(input int p, input int ax, input int ay, input int bx, input int by,
                         input int cx, input int cy, input int col, input int dep);
    if (p == 0) begin
      v0_x_in[6:0] = 7'(ax); v0_y_in[5:0] = 6'(ay);
      v1_x_in[6:0] = 7'(bx); v1_y_in[5:0] = 6'(by);
      v2_x_in[6:0] = 7'(cx); v2_y_in[5:0] = 6'(cy);
      poly_color_in[5:0] = 6'(col); poly_depth_in[2:0] = 3'(dep);
    end else begin
      v0_x_in[13:7] = 7'(ax); v0_y_in[11:6] = 6'(ay);
      v1_x_in[13:7] = 7'(bx); v1_y_in[11:6] = 6'(by);
      v2_x_in[13:7] = 7'(cx); v2_y_in[11:6] = 6'(cy);
      poly_color_in[11:6] = 6'(col); poly_depth_in[5:3] = 3'(dep);
    end
  endtask

  task automatic wait_setup();
    busy_cnt = 0;
    while (setup_busy && busy_cnt < 40) begin
      busy_cnt++;
      tick();
    end
  endtask

  // One full line: strobe every other cycle, record colour/valid and whether valid lingered.
  task automatic run_line(input int y, input int chg_x, input int chg_col);
    line_y = 6'(y);
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
    wait_setup();
    for (int xi = 0; xi < 128; xi++) begin
      if (xi == chg_x) poly_color_in[5:0] = 6'(chg_col);
      pix_step = 1'b1;
      tick();
      pix_step = 1'b0;
      pix_col[xi] = color_out;
      pix_vld[xi] = color_valid;
      tick();
      pix_hold[xi] = color_valid;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    n_checks++;
    if (color_out !== 6'h00 || color_valid !== 1'b0 || setup_busy !== 1'b0 || late_pulse !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: out=%h vld=%b busy=%b late=%b, required 00/0/0/0",
               color_out, color_valid, setup_busy, late_pulse);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_tri_a();
    int nv;
    bg_color_in = 6'h05;
    set_tri(0, 10, 10, 20, 10, 10, 20, 6'h30, 2);
    poly_enable_in = 2'b01;
    run_line(12, -1, 0);
    n_checks++;
    if (busy_cnt !== 13) begin n_fail++; $display("FAIL busy_width: got %0d, required 13", busy_cnt); end
    n_checks++;
    if (pix_col[12] !== 6'h30) begin n_fail++; $display("FAIL tri_a_inside: x=12 got %h, required 30", pix_col[12]); end
    n_checks++;
    if (pix_col[25] !== 6'h05) begin n_fail++; $display("FAIL tri_a_outside: x=25 got %h, required 05", pix_col[25]); end
    n_checks++;
    if (pix_col[10] !== 6'h30) begin n_fail++; $display("FAIL tri_a_edge_left: x=10 got %h, required 30", pix_col[10]); end
    n_checks++;
    if (pix_col[9] !== 6'h05) begin n_fail++; $display("FAIL tri_a_left_out: x=9 got %h, required 05", pix_col[9]); end
    n_checks++;
    if (pix_col[18] !== 6'h30) begin n_fail++; $display("FAIL tri_a_edge_right: x=18 got %h, required 30", pix_col[18]); end
    n_checks++;
    if (pix_col[19] !== 6'h05) begin n_fail++; $display("FAIL tri_a_right_out: x=19 got %h, required 05", pix_col[19]); end
    n_checks++;
    if (pix_vld[12] !== 1'b1 || pix_hold[12] !== 1'b0) begin
      n_fail++;
      $display("FAIL latency_one_cycle: vld=%b hold=%b, required 1/0", pix_vld[12], pix_hold[12]);
    end
    nv = 0;
    for (int i = 0; i < 128; i++) if (pix_vld[i] === 1'b1) nv++;
    n_checks++;
    if (nv !== 128) begin n_fail++; $display("FAIL valid_count: got %0d, required 128", nv); end
  endtask

  task automatic test_overlap();
    set_tri(1, 10, 10, 20, 10, 10, 20, 6'h0C, 1);
    poly_enable_in = 2'b11;
    run_line(12, -1, 0);
    n_checks++;
    if (pix_col[12] !== 6'h0C) begin n_fail++; $display("FAIL overlap_b_nearer: got %h, required 0c", pix_col[12]); end
    poly_depth_in[5:3] = 3'd2;
    run_line(12, -1, 0);
    n_checks++;
    if (pix_col[12] !== 6'h30) begin n_fail++; $display("FAIL overlap_tie_a: got %h, required 30", pix_col[12]); end
  endtask

  task automatic test_winding();
    set_tri(1, 10, 10, 10, 20, 20, 10, 6'h0C, 1);
    poly_enable_in = 2'b10;
    run_line(12, -1, 0);
    n_checks++;
    if (pix_col[12] !== 6'h0C) begin n_fail++; $display("FAIL reverse_winding: got %h, required 0c", pix_col[12]); end
    n_checks++;
    if (pix_col[25] !== 6'h05) begin n_fail++; $display("FAIL reverse_outside: got %h, required 05", pix_col[25]); end
    set_tri(0, 5, 5, 10, 5, 15, 5, 6'h30, 2);
    poly_enable_in = 2'b01;
    run_line(5, -1, 0);
    n_checks++;
    if (pix_col[8] !== 6'h05) begin n_fail++; $display("FAIL zero_area: got %h, required 05", pix_col[8]); end
  endtask

  task automatic test_late_restart();
    set_tri(0, 10, 10, 20, 10, 10, 20, 6'h30, 2);
    line_y = 6'd12;
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
    tick(); tick();
    pix_step = 1'b1;
    tick();
    pix_step = 1'b0;
    n_checks++;
    if (late_pulse !== 1'b1 || color_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL late_in_setup: late=%b vld=%b, required 1/0", late_pulse, color_valid);
    end
    tick();
    n_checks++;
    if (late_pulse !== 1'b0) begin n_fail++; $display("FAIL late_single: late=%b, required 0", late_pulse); end
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
    wait_setup();
    n_checks++;
    if (busy_cnt !== 13) begin n_fail++; $display("FAIL setup_restart: busy %0d, required 13", busy_cnt); end
  endtask

  task automatic test_snapshot();
    set_tri(0, 10, 10, 20, 10, 10, 20, 6'h30, 2);
    poly_enable_in = 2'b01;
    run_line(12, 11, 6'h3F);
    n_checks++;
    if (pix_col[12] !== 6'h30 || pix_col[18] !== 6'h30) begin
      n_fail++;
      $display("FAIL snapshot_hold: x12=%h x18=%h, required 30/30", pix_col[12], pix_col[18]);
    end
    n_checks++;
    if (pix_vld[127] !== 1'b1) begin n_fail++; $display("FAIL last_pixel: vld=%b, required 1", pix_vld[127]); end
    pix_step = 1'b1;
    tick();
    pix_step = 1'b0;
    n_checks++;
    if (color_valid !== 1'b0 || late_pulse !== 1'b0) begin
      n_fail++;
      $display("FAIL beyond_xmax: vld=%b late=%b, required 0/0", color_valid, late_pulse);
    end
    run_line(12, -1, 0);
    n_checks++;
    if (pix_col[12] !== 6'h3F) begin n_fail++; $display("FAIL snapshot_next: got %h, required 3f", pix_col[12]); end
  endtask

  task automatic test_async_reset();
    poly_color_in[5:0] = 6'h30;
    line_y = 6'd12;
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
    wait_setup();
    for (int xi = 0; xi <= 12; xi++) begin
      pix_step = 1'b1;
      tick();
      pix_step = 1'b0;
    end
    n_checks++;
    if (color_valid !== 1'b1 || color_out !== 6'h30) begin
      n_fail++;
      $display("FAIL pre_reset_pixel: vld=%b out=%h, required 1/30", color_valid, color_out);
    end
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if (color_out !== 6'h00 || color_valid !== 1'b0 || setup_busy !== 1'b0 || late_pulse !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset_active: out=%h vld=%b busy=%b late=%b, required 00/0/0/0",
               color_out, color_valid, setup_busy, late_pulse);
    end
    tick();
    rst_n = 1'b1;
    pix_step = 1'b1;
    tick();
    pix_step = 1'b0;
    n_checks++;
    if (late_pulse !== 1'b1 || color_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_reset: late=%b vld=%b, required 1/0", late_pulse, color_valid);
    end
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
    tick(); tick();
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if (setup_busy !== 1'b0) begin n_fail++; $display("FAIL async_reset_setup: busy=%b, required 0", setup_busy); end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_tri_a();
    test_overlap();
    test_winding();
    test_late_restart();
    test_snapshot();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
